// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_RESUME   = 2'd3
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and the control strobes / statistics returned to it.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             branch_taken;
    logic             jump_id;
    logic             mem_req;
    logic             halt_req;
    logic             resume;

    logic             pc_go;
    logic             if_id_go;
    logic             id_exe_go;
    logic             exe_mem_go;
    logic             mem_wb_go;
    logic             if_id_clear;
    logic             id_exe_clear;
    logic             exe_mem_clear;
    logic             mem_wb_clear;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               branch_taken, jump_id, mem_req, halt_req, resume,
        input  pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go,
               if_id_clear, id_exe_clear, exe_mem_clear, mem_wb_clear,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               branch_taken, jump_id, mem_req, halt_req, resume,
        output pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go,
               if_id_clear, id_exe_clear, exe_mem_clear, mem_wb_clear,
               halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Saturating increment with synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage advance/bubble strobes from load-use, branch, jump,
// multi-cycle memory and syscall halt/resume events, plus stall/flush statistics.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int                WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic              MEM_EN    = (MEM_LAT > 0);
    localparam logic [WAIT_W-1:0] WAIT_INIT = (MEM_LAT > 1) ? WAIT_W'(MEM_LAT - 1) : {WAIT_W{1'b0}};

    ctrl_state_e       state_r;
    ctrl_state_e       state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              rs_hit_s;
    logic              rt_hit_s;
    logic              load_use_s;
    logic [4:0]        go_s;      // {pc, if_id, id_exe, exe_mem, mem_wb}
    logic [3:0]        clr_s;     // {if_id, id_exe, exe_mem, mem_wb}
    logic              halted_s;
    logic              stall_inc_s;
    logic              flush_inc_s;
    logic [CNT_W-1:0]  stall_cnt_s;
    logic [CNT_W-1:0]  flush_cnt_s;

    assign rs_hit_s   = bus.id_uses_rs && (bus.id_rs == bus.ex_rd);
    assign rt_hit_s   = bus.id_uses_rt && (bus.id_rt == bus.ex_rd);
    assign load_use_s = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) && (rs_hit_s || rt_hit_s);

    // Next-state, wait count and strobe decode
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        go_s        = 5'b11111;
        clr_s       = 4'b0000;
        halted_s    = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_r)
            ST_RUN, ST_RESUME: begin
                // RESUME masks halt_req and mem_req so the syscall can leave WB
                state_nxt_s = ST_RUN;
                if ((state_r == ST_RUN) && bus.halt_req) begin
                    go_s        = 5'b00000;
                    state_nxt_s = ST_HALT;
                end else if ((state_r == ST_RUN) && bus.mem_req && MEM_EN) begin
                    go_s        = 5'b00000;
                    state_nxt_s = ST_MEM_WAIT;
                    wait_nxt_s  = WAIT_INIT;
                    stall_inc_s = 1'b1;
                end else if (bus.branch_taken) begin
                    clr_s       = 4'b1100;
                    flush_inc_s = 1'b1;
                end else if (load_use_s) begin
                    go_s        = 5'b00111;
                    clr_s       = 4'b0100;
                    stall_inc_s = 1'b1;
                end else if (bus.jump_id) begin
                    clr_s       = 4'b1000;
                    flush_inc_s = 1'b1;
                end else begin
                    clr_s       = 4'b0000;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_r != {WAIT_W{1'b0}}) begin
                    go_s        = 5'b00000;
                    wait_nxt_s  = wait_cnt_r - WAIT_W'(1);
                    stall_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                go_s     = 5'b00000;
                halted_s = 1'b1;
                if (bus.resume) begin
                    state_nxt_s = ST_RESUME;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .clear (1'b0),
        .count (stall_cnt_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .clear (1'b0),
        .count (flush_cnt_s)
    );

    // In reset the PC holds while every pipeline register loads a bubble
    assign bus.pc_go         = rst_n ? go_s[4]  : 1'b0;
    assign bus.if_id_go      = rst_n ? go_s[3]  : 1'b1;
    assign bus.id_exe_go     = rst_n ? go_s[2]  : 1'b1;
    assign bus.exe_mem_go    = rst_n ? go_s[1]  : 1'b1;
    assign bus.mem_wb_go     = rst_n ? go_s[0]  : 1'b1;
    assign bus.if_id_clear   = rst_n ? clr_s[3] : 1'b1;
    assign bus.id_exe_clear  = rst_n ? clr_s[2] : 1'b1;
    assign bus.exe_mem_clear = rst_n ? clr_s[1] : 1'b1;
    assign bus.mem_wb_clear  = rst_n ? clr_s[0] : 1'b1;
    assign bus.halted        = rst_n & halted_s;
    assign bus.stall_cnt     = stall_cnt_s;
    assign bus.flush_cnt     = flush_cnt_s;

endmodule
